// File: rtl/fft_sample_pingpong_buf.sv
// Ping-pong buffer for complex FFT snapshots: parallel capture, serial stream out
// (natural or bit-reversed order), plus a 1-cycle random-access debug read port.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   cap_*        parallel snapshot input with valid/ready and per-snapshot order select
//   out_*        serial sample stream {re, im} with memory index and last-beat flag
//   rd_*         random-access read of the most recently captured bank
//   drop_cnt     saturating count of cycles where a snapshot was offered but refused
module fft_sample_pingpong_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 4,
  parameter int DROP_W     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cap_valid,
  output logic                                 cap_ready,
  input  logic                                 cap_bitrev,
  input  logic [(1<<LOG2_N)*DATA_WIDTH-1:0]    cap_re,
  input  logic [(1<<LOG2_N)*DATA_WIDTH-1:0]    cap_im,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*DATA_WIDTH-1:0]              out_data,
  output logic [LOG2_N-1:0]                    out_idx,
  output logic                                 out_last,
  input  logic                                 rd_en,
  input  logic [LOG2_N-1:0]                    rd_addr,
  output logic [2*DATA_WIDTH-1:0]              rd_data,
  output logic [DROP_W-1:0]                    drop_cnt
);

  localparam int N = 1 << LOG2_N;
  localparam int W = 2 * DATA_WIDTH;

  localparam logic [LOG2_N-1:0] CNT_ONE  = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  // Storage and bank bookkeeping
  logic [W-1:0]      r_mem [2][N];
  logic [1:0]        r_full;
  logic [1:0]        r_bitrev;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic              r_last_bank;

  // Stream control
  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOG2_N-1:0] r_cnt;
  logic [LOG2_N-1:0] w_cnt_nxt;
  logic              w_cnt_last;
  logic              w_release;
  logic              w_out_valid;
  logic [LOG2_N-1:0] w_out_idx;

  // Capture side
  logic              w_cap;
  logic              w_drop;

  // Debug read and drop counter
  logic [W-1:0]      r_rd_data;
  logic [DROP_W-1:0] r_drop;

  function automatic logic [LOG2_N-1:0] f_rev(
    input logic [LOG2_N-1:0] a
  );
    logic [LOG2_N-1:0] r;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = a[LOG2_N-1-i];
    end
    return r;
  endfunction

  // Ready depends only on registered state, never on cap_valid.
  assign cap_ready = ~r_full[r_wr_bank];
  assign w_cap     = cap_valid & ~r_full[r_wr_bank];
  assign w_drop    = cap_valid &  r_full[r_wr_bank];

  assign w_cnt_last = &r_cnt;
  assign w_out_idx  = r_bitrev[r_rd_bank] ? f_rev(r_cnt) : r_cnt;

  // Next-state and stream outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = S_STREAM;
          w_cnt_nxt   = '0;
        end
      end
      S_STREAM: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          if (w_cnt_last) begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The streamed bank is full, so capture can never overwrite it;
  // this keeps data/idx/last stable during a stall.
  assign out_valid = w_out_valid;
  assign out_idx   = w_out_valid ? w_out_idx : '0;
  assign out_last  = w_out_valid & w_cnt_last;
  assign out_data  = w_out_valid ? r_mem[r_rd_bank][w_out_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Bank pointers and per-bank flags. Capture and release never
  // target the same bank in one cycle: capture needs it empty,
  // release needs it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 2'b00;
      r_bitrev    <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_last_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_cap && (r_wr_bank == 1'(b))) begin
          r_full[b]   <= 1'b1;
          r_bitrev[b] <= cap_bitrev;
        end else if (w_release && (r_rd_bank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
      if (w_cap) begin
        r_last_bank <= r_wr_bank;
        r_wr_bank   <= ~r_wr_bank;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Bank contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int k = 0; k < N; k++) begin
        r_mem[r_wr_bank][k] <= {cap_re[k*DATA_WIDTH +: DATA_WIDTH],
                                cap_im[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[r_last_bank][rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_ONE;
    end
  end

  assign rd_data  = r_rd_data;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_fft_sample_pingpong_buf.sv
// Directed bench for fft_sample_pingpong_buf with a stream scoreboard.
// Expected beats are queued at capture time and popped on each handshake.
module tb_fft_sample_pingpong_buf;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int N   = 16;
  localparam int DRW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cap_valid = 1'b0;
  logic            cap_ready;
  logic            cap_bitrev = 1'b0;
  logic [N*DW-1:0] cap_re = '0;
  logic [N*DW-1:0] cap_im = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] out_data;
  logic [LN-1:0]   out_idx;
  logic            out_last;
  logic            rd_en = 1'b0;
  logic [LN-1:0]   rd_addr = '0;
  logic [2*DW-1:0] rd_data;
  logic [DRW-1:0]  drop_cnt;

  fft_sample_pingpong_buf #(
    .DATA_WIDTH(DW),
    .LOG2_N    (LN),
    .DROP_W    (DRW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_bitrev(cap_bitrev),
    .cap_re    (cap_re),
    .cap_im    (cap_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pw(input int p, input int k);
    logic [15:0] re;
    logic [15:0] im;
    case (p)
      0: begin re = 16'(k);         im = 16'(-k);     end
      1: begin re = 16'(100 + k);   im = 16'(3 * k);  end
      default: begin
        re = 16'(16'hA000 + 7 * k);
        im = 16'(k << 8);
      end
    endcase
    return {re, im};
  endfunction

  function automatic logic [3:0] rev(input int j);
    logic [3:0] a;
    logic [3:0] r;
    a = 4'(j);
    for (int b = 0; b < 4; b++) r[b] = a[3-b];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cap(input int p, input bit br);
    logic [31:0] w;
    exp_t        e;
    for (int k = 0; k < N; k++) begin
      w = pw(p, k);
      cap_re[k*DW +: DW] = w[31:16];
      cap_im[k*DW +: DW] = w[15:0];
    end
    cap_valid  = 1'b1;
    cap_bitrev = br;
    for (int j = 0; j < N; j++) begin
      e.idx  = br ? rev(j) : 4'(j);
      e.data = pw(p, int'(e.idx));
      e.last = (j == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    chk(tag, 64'(q.size()), 0);
  endtask

  // Stream monitor: scoreboard pop on handshakes, hold check on stalls.
  logic        stalled = 1'b0;
  logic [3:0]  s_idx;
  logic [31:0] s_data;
  logic        s_last;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 1);
        chk("stall_idx",   64'(out_idx),   64'(s_idx));
        chk("stall_data",  64'(out_data),  64'(s_data));
        chk("stall_last",  64'(out_last),  64'(s_last));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          m_e = q.pop_front();
          chk("beat_idx",  64'(out_idx),  64'(m_e.idx));
          chk("beat_data", 64'(out_data), 64'(m_e.data));
          chk("beat_last", 64'(out_last), 64'(m_e.last));
        end
      end
      stalled = out_valid && !out_ready;
      s_idx   = out_idx;
      s_data  = out_data;
      s_last  = out_last;
    end
  end

  initial begin
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_cap_ready", 64'(cap_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data",  64'(out_data),  0);
    chk("rst_out_idx",   64'(out_idx),   0);
    chk("rst_out_last",  64'(out_last),  0);
    chk("rst_rd_data",   64'(rd_data),   0);
    chk("rst_drop_cnt",  64'(drop_cnt),  0);

    // Natural order, two-cycle first-sample latency
    out_ready = 1'b1;
    drive_cap(0, 1'b0);
    step();
    cap_valid = 1'b0;
    chk("t1_lat_cycle1", 64'(out_valid), 0);
    step();
    chk("t1_lat_cycle2", 64'(out_valid), 1);
    chk("t1_first_idx",  64'(out_idx),   0);
    chk("t1_first_data", 64'(out_data),  64'(pw(0, 0)));
    drain("t1_drain", 100);
    step();

    // Bit-reversed order
    drive_cap(0, 1'b1);
    step();
    cap_valid = 1'b0;
    step();
    chk("t2_idx_beat0", 64'(out_idx), 0);
    step();
    chk("t2_idx_beat1", 64'(out_idx), 8);
    drain("t2_drain", 100);
    step();

    // Both banks full, drops, then A, one bubble, B
    out_ready = 1'b0;
    drive_cap(0, 1'b0);
    step();
    drive_cap(1, 1'b0);
    step();
    cap_valid = 1'b0;
    chk("t3_ready_full", 64'(cap_ready), 0);
    chk("t3_a_waiting",  64'(out_valid), 1);
    cap_valid = 1'b1;
    repeat (5) step();
    cap_valid = 1'b0;
    chk("t3_drop5", 64'(drop_cnt), 5);
    step();
    chk("t3_drop_hold", 64'(drop_cnt), 5);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (q.size() == N) break;
    end
    chk("t3_a_done",     64'(q.size()),  64'(N));
    chk("t3_bubble",     64'(out_valid), 0);
    chk("t3_ready_free", 64'(cap_ready), 1);
    step();
    chk("t3_b_start", 64'(out_valid), 1);
    chk("t3_b_data",  64'(out_data),  64'(pw(1, 0)));
    drain("t3_drain", 100);
    step();

    // Random backpressure
    out_ready = 1'b0;
    drive_cap(2, 1'b0);
    step();
    cap_valid = 1'b0;
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    drain("t4_drain", 100);
    step();

    // Random-access read port
    drive_cap(0, 1'b0);
    step();
    cap_valid = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    step();
    chk("t5_rd_addr3", 64'(rd_data), 64'({16'd3, 16'hFFFD}));
    rd_en = 1'b0;
    step();
    chk("t5_rd_off", 64'(rd_data), 0);
    rd_en = 1'b1;
    drive_cap(1, 1'b0);
    step();
    cap_valid = 1'b0;
    chk("t5_rd_same_edge", 64'(rd_data), 64'(pw(0, 3)));
    step();
    chk("t5_rd_new_bank", 64'(rd_data), 64'(pw(1, 3)));
    rd_en = 1'b0;
    drain("t5_drain", 200);
    step();

    // Reset in the middle of a stream
    drive_cap(0, 1'b0);
    step();
    cap_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_idx == 4'd7) break;
      step();
    end
    chk("t6_at_beat7", 64'(out_idx), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_cap_ready", 64'(cap_ready), 1);
    chk("t6_drop_cnt",  64'(drop_cnt),  0);
    chk("t6_out_last",  64'(out_last),  0);
    repeat (3) step();
    chk("t6_discarded", 64'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
